// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_fifo
//  Purpose  : Capture stage behind the 4-bit ALU (invert/add/subtract/double).
//             Each accepted result is tagged with its op, the carry that
//             belongs to that op and a zero flag. It is then queued in a
//             DEPTH-entry FIFO that is drained through a valid/ready handshake.
//  Ports    : clk_in, rst_in (async, active high), clear_in (sync flush)
//             upstream   : valid_in, ready_out, op_in, result_in,
//                          c_add_in, c_sub_in, c_dbl_in
//             downstream : valid_out, ready_in, op_out, result_out,
//                          carry_out, zero_out
//             status     : count_out, overflow_out (sticky drop flag)
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_fifo #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              clear_in,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic [1:0]        op_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic              c_add_in,
   input  logic              c_sub_in,
   input  logic              c_dbl_in,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [1:0]        op_out,
   output logic [DATA_W-1:0] result_out,
   output logic              carry_out,
   output logic              zero_out,
   output logic [CNT_W-1:0]  count_out,
   output logic              overflow_out
);

   localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Entry layout, MSB first: {op, result, carry, zero}
   localparam int c_entry_w = 2 + DATA_W + 2;

   localparam logic [CNT_W-1:0]   c_depth   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

   localparam logic [1:0] c_op_inv = 2'b00;
   localparam logic [1:0] c_op_add = 2'b01;
   localparam logic [1:0] c_op_sub = 2'b10;
   localparam logic [1:0] c_op_dbl = 2'b11;

   logic [c_entry_w-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_overflow;

   logic                 w_carry_sel;
   logic                 w_zero;
   logic [c_entry_w-1:0] w_entry;
   logic [c_entry_w-1:0] w_head;
   logic                 w_push;
   logic                 w_pop;

   // Keep only the carry produced by the selected operation; invert has none.
   always_comb begin
      w_carry_sel = 1'b0;
      case (op_in)
         c_op_inv: w_carry_sel = 1'b0;
         c_op_add: w_carry_sel = c_add_in;
         c_op_sub: w_carry_sel = c_sub_in;
         c_op_dbl: w_carry_sel = c_dbl_in;
         default:  w_carry_sel = 1'b0;
      endcase
   end

   assign w_zero  = (result_in == '0);
   assign w_entry = {op_in, result_in, w_carry_sel, w_zero};

   // Handshake flags come from registered count only, so neither valid_in
   // nor ready_in has a combinational path to ready_out / valid_out.
   assign ready_out = (r_count < c_depth);
   assign valid_out = (r_count != '0);

   assign w_push = valid_in & ready_out;
   assign w_pop  = valid_out & ready_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (clear_in) begin
         // Flush bookkeeping only; stale entries stay in storage and are
         // hidden by valid_out until overwritten.
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
            r_wr_ptr        <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
         // Full is judged on the registered count: a pop in the same cycle
         // frees a slot only for the following cycle, so this entry is lost.
         if (valid_in && !ready_out) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Head always reflects the slot at the read pointer; consumers gate with valid_out.
   assign w_head = r_mem[r_rd_ptr];

   assign op_out       = w_head[c_entry_w-1 -: 2];
   assign result_out   = w_head[2 +: DATA_W];
   assign carry_out    = w_head[1];
   assign zero_out     = w_head[0];
   assign count_out    = r_count;
   assign overflow_out = r_overflow;

endmodule
`default_nettype wire
